// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), opcode dispatch at T3, and
// per-instruction execute steps up to T7, with an absorbing HALT state.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        con_ff,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLOin,
  output logic        Rin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  operation,
  output logic        Run
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_LDI    = 5'b00001;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_AND    = 5'b00101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_ADDI   = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b10010;
  localparam logic [4:0] OP_JR     = 5'b10100;
  localparam logic [4:0] OP_NOP    = 5'b11010;

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic       is_alu, is_imm, is_mem;

  // Register fields are consumed by the external select/encode logic, not here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  assign opcode = IR[31:27];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_LDI);
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= T0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    ZLOin     = 1'b0;
    Rin       = 1'b0;
    CONin     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    operation = 5'b00000;
    Run       = 1'b1;

    // Strobes are masked while clr is high, even though the state is already T0.
    if (!clr) begin
      unique case (state_q)
        T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
          state_d = T1;
        end
        T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
          if (mem_ready) state_d = T2;
        end
        T2: begin
          MDRout = 1'b1; IRin = 1'b1;
          state_d = T3;
        end
        T3: begin
          if (is_alu || opcode == OP_ADDI) begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = T4;
          end else if (opcode == OP_LDI || is_mem) begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = T4;
          end else if (opcode == OP_BRANCH) begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = T4;
          end else if (opcode == OP_JR) begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_d = T0;
          end else if (opcode == OP_NOP) begin
            state_d = T0;
          end else begin
            state_d = HALT;
          end
        end
        T4: begin
          if (is_alu) begin
            Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode; state_d = T5;
          end else if (is_imm || is_mem) begin
            Cout = 1'b1; ZLOin = 1'b1; operation = ADD_OP; state_d = T5;
          end else if (opcode == OP_BRANCH) begin
            PCout = 1'b1; Yin = 1'b1; state_d = T5;
          end else begin
            state_d = HALT;
          end
        end
        T5: begin
          if (is_alu || is_imm) begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = T0;
          end else if (is_mem) begin
            Zlowout = 1'b1; MARin = 1'b1; state_d = T6;
          end else if (opcode == OP_BRANCH) begin
            Cout = 1'b1; ZLOin = 1'b1; operation = ADD_OP; state_d = T6;
          end else begin
            state_d = HALT;
          end
        end
        T6: begin
          if (opcode == OP_LD) begin
            Read = 1'b1; MDRin = 1'b1;
            if (mem_ready) state_d = T7;
          end else if (opcode == OP_ST) begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = T7;
          end else if (opcode == OP_BRANCH) begin
            Zlowout = con_ff; PCin = con_ff; state_d = T0;
          end else begin
            state_d = HALT;
          end
        end
        T7: begin
          if (opcode == OP_LD) begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = T0;
          end else if (opcode == OP_ST) begin
            Write = 1'b1;
            if (mem_ready) state_d = T0;
          end else begin
            state_d = HALT;
          end
        end
        HALT: begin
          Run = 1'b0;
        end
        default: begin
          state_d = T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/operation/Run vectors for
// each instruction class, memory waits, branch outcomes, halt and reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        mem_ready;
  logic        con_ff;
  logic PCout, Zlowout, MDRout, Cout, Rout, BAout;
  logic PCin, MARin, MDRin, IRin, Yin, ZLOin, Rin, CONin;
  logic IncPC, Read, Write, Gra, Grb, Grc;
  logic [4:0] operation;
  logic Run;

  int total  = 0;
  int passed = 0;

  control_unit #(.ADD_OP(5'b00011)) dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready), .con_ff(con_ff),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .Rout(Rout),
    .BAout(BAout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .ZLOin(ZLOin), .Rin(Rin), .CONin(CONin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .operation(operation), .Run(Run)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] S_PCOUT   = 20'd1 << 19;
  localparam logic [19:0] S_ZLOWOUT = 20'd1 << 18;
  localparam logic [19:0] S_MDROUT  = 20'd1 << 17;
  localparam logic [19:0] S_COUT    = 20'd1 << 16;
  localparam logic [19:0] S_ROUT    = 20'd1 << 15;
  localparam logic [19:0] S_BAOUT   = 20'd1 << 14;
  localparam logic [19:0] S_PCIN    = 20'd1 << 13;
  localparam logic [19:0] S_MARIN   = 20'd1 << 12;
  localparam logic [19:0] S_MDRIN   = 20'd1 << 11;
  localparam logic [19:0] S_IRIN    = 20'd1 << 10;
  localparam logic [19:0] S_YIN     = 20'd1 << 9;
  localparam logic [19:0] S_ZLOIN   = 20'd1 << 8;
  localparam logic [19:0] S_RIN     = 20'd1 << 7;
  localparam logic [19:0] S_CONIN   = 20'd1 << 6;
  localparam logic [19:0] S_INCPC   = 20'd1 << 5;
  localparam logic [19:0] S_READ    = 20'd1 << 4;
  localparam logic [19:0] S_WRITE   = 20'd1 << 3;
  localparam logic [19:0] S_GRA     = 20'd1 << 2;
  localparam logic [19:0] S_GRB     = 20'd1 << 1;
  localparam logic [19:0] S_GRC     = 20'd1 << 0;

  localparam logic [19:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZLOIN;
  localparam logic [19:0] F_T1 = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [19:0] F_T2 = S_MDROUT | S_IRIN;

  function automatic logic [19:0] strobes();
    return {PCout, Zlowout, MDRout, Cout, Rout, BAout, PCin, MARin, MDRin, IRin,
            Yin, ZLOin, Rin, CONin, IncPC, Read, Write, Gra, Grb, Grc};
  endfunction

  // Each test starts and ends 1 time unit after a falling edge with the DUT in T0.
  task automatic test_reset();
    clr = 1'b1; IR = 32'h0; mem_ready = 1'b0; con_ff = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (strobes() !== 20'h0 || operation !== 5'd0 || Run !== 1'b1)
      $display("FAIL reset_held: strobes=%05h op=%05b Run=%b, required strobes=00000 op=00000 Run=1",
               strobes(), operation, Run);
    else passed++;
    @(negedge clk);
    clr = 1'b0;
    #1;
    total++;
    if (strobes() !== F_T0 || operation !== 5'd0 || Run !== 1'b1)
      $display("FAIL reset_release_t0: strobes=%05h op=%05b Run=%b, required strobes=%05h op=00000 Run=1",
               strobes(), operation, Run, F_T0);
    else passed++;
  endtask

  task automatic test_alu(input logic [31:0] ir, input logic [4:0] op, input string tag);
    logic [19:0] es[$];
    logic [4:0]  eo[$];
    logic        mr[$];
    IR = ir;
    es = '{F_T0, F_T1, F_T2, S_GRB | S_ROUT | S_YIN, S_GRC | S_ROUT | S_ZLOIN,
           S_ZLOWOUT | S_GRA | S_RIN, F_T0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, op, 5'd0, 5'd0};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      total++;
      if (strobes() !== es[i] || operation !== eo[i] || Run !== 1'b1)
        $display("FAIL %s step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=%05b Run=1",
                 tag, i, strobes(), operation, Run, es[i], eo[i]);
      else passed++;
    end
  endtask

  task automatic test_imm(input logic ldi);
    logic [19:0] es[$];
    logic [4:0]  eo[$];
    IR = ldi ? 32'h08880007 : 32'h60880007;
    mem_ready = 1'b1;
    es = '{F_T0, F_T1, F_T2, S_GRB | (ldi ? S_BAOUT : S_ROUT) | S_YIN,
           S_COUT | S_ZLOIN, S_ZLOWOUT | S_GRA | S_RIN, F_T0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (strobes() !== es[i] || operation !== eo[i] || Run !== 1'b1)
        $display("FAIL %s step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=%05b Run=1",
                 ldi ? "ldi" : "addi", i, strobes(), operation, Run, es[i], eo[i]);
      else passed++;
    end
  endtask

  task automatic test_ld_wait();
    logic [19:0] es[$];
    logic [4:0]  eo[$];
    logic        mr[$];
    localparam logic [19:0] RM = S_READ | S_MDRIN;
    IR = 32'h00800055;
    es = '{F_T0, F_T1, F_T2, S_GRB | S_BAOUT | S_YIN, S_COUT | S_ZLOIN,
           S_ZLOWOUT | S_MARIN, RM, RM, RM, RM, S_MDROUT | S_GRA | S_RIN, F_T0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      total++;
      if (strobes() !== es[i] || operation !== eo[i] || Run !== 1'b1)
        $display("FAIL ld_wait step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=%05b Run=1",
                 i, strobes(), operation, Run, es[i], eo[i]);
      else passed++;
    end
  endtask

  task automatic test_st(input int waits);
    logic [19:0] es[$];
    logic [4:0]  eo[$];
    logic        mr[$];
    IR = 32'h10880010;
    es = '{F_T0, F_T1, F_T2, S_GRB | S_BAOUT | S_YIN, S_COUT | S_ZLOIN,
           S_ZLOWOUT | S_MARIN, S_GRA | S_ROUT | S_MDRIN};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int w = 0; w < waits; w++) begin
      es.push_back(S_WRITE); eo.push_back(5'd0); mr.push_back(1'b0);
    end
    es.push_back(S_WRITE); eo.push_back(5'd0); mr.push_back(1'b1);
    es.push_back(F_T0);    eo.push_back(5'd0); mr.push_back(1'b1);
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      total++;
      if (strobes() !== es[i] || operation !== eo[i] || Run !== 1'b1)
        $display("FAIL st_wait%0d step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=%05b Run=1",
                 waits, i, strobes(), operation, Run, es[i], eo[i]);
      else passed++;
    end
  endtask

  task automatic test_branch(input logic cond);
    logic [19:0] es[$];
    logic [4:0]  eo[$];
    IR = 32'h92800000;
    con_ff = cond;
    mem_ready = 1'b1;
    es = '{F_T0, F_T1, F_T2, S_GRA | S_ROUT | S_CONIN, S_PCOUT | S_YIN,
           S_COUT | S_ZLOIN, cond ? (S_ZLOWOUT | S_PCIN) : 20'h0, F_T0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (strobes() !== es[i] || operation !== eo[i] || Run !== 1'b1)
        $display("FAIL branch_con%0d step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=%05b Run=1",
                 cond, i, strobes(), operation, Run, es[i], eo[i]);
      else passed++;
    end
    con_ff = 1'b0;
  endtask

  task automatic test_short(input logic [31:0] ir, input logic [19:0] t3, input string tag);
    logic [19:0] es[$];
    IR = ir;
    mem_ready = 1'b1;
    es = '{F_T0, F_T1, F_T2, t3, F_T0};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (strobes() !== es[i] || operation !== 5'd0 || Run !== 1'b1)
        $display("FAIL %s step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=00000 Run=1",
                 tag, i, strobes(), operation, Run, es[i]);
      else passed++;
    end
  endtask

  task automatic test_clr_mid_wait();
    logic [19:0] es[$];
    logic        mr[$];
    logic        cl[$];
    IR = 32'h191A0000;
    es = '{F_T0, F_T1, F_T1, 20'h0, F_T0};
    mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      clr = cl[i];
      #1;
      total++;
      if (strobes() !== es[i] || operation !== 5'd0 || Run !== 1'b1)
        $display("FAIL clr_mid_wait step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=00000 Run=1",
                 i, strobes(), operation, Run, es[i]);
      else passed++;
    end
  endtask

  task automatic test_halt(input logic [31:0] ir, input string tag);
    logic [19:0] es[$];
    logic        er[$];
    logic        cl[$];
    IR = ir;
    mem_ready = 1'b1;
    es = '{F_T0, F_T1, F_T2, 20'h0};
    er = '{1'b1, 1'b1, 1'b1, 1'b1};
    cl = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 20; c++) begin
      es.push_back(20'h0); er.push_back(1'b0); cl.push_back(1'b0);
    end
    es.push_back(20'h0); er.push_back(1'b1); cl.push_back(1'b1);
    es.push_back(F_T0);  er.push_back(1'b1); cl.push_back(1'b0);
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = i[0];
      clr = cl[i];
      #1;
      total++;
      if (strobes() !== es[i] || operation !== 5'd0 || Run !== er[i])
        $display("FAIL %s step%0d: strobes=%05h op=%05b Run=%b, required strobes=%05h op=00000 Run=%b",
                 tag, i, strobes(), operation, Run, es[i], er[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu(32'h191A0000, 5'b00011, "add");
    test_alu(32'h211A0000, 5'b00100, "sub");
    test_alu(32'h311A0000, 5'b00110, "or");
    test_imm(1'b0);
    test_imm(1'b1);
    test_ld_wait();
    test_st(0);
    test_st(2);
    test_branch(1'b0);
    test_branch(1'b1);
    test_short(32'hA0800000, S_GRA | S_ROUT | S_PCIN, "jr");
    test_short(32'hD0000000, 20'h0, "nop");
    test_clr_mid_wait();
    test_halt(32'hD8000000, "halt");
    test_halt(32'hF8000000, "undef");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
